dual_port_fifo_ctrl: RTL and testbench
======================================

# dual_port_fifo_ctrl

Flow-controlled FIFO built around the team's `DualPortBuffer` (one write port, one registered read port, 1-cycle read latency, externally supplied pointers).
- Owns write/read pointer generation, occupancy tracking and full/empty detection.
- Guarantees the buffer never sees a same-address read/write hazard.
- Presents a valid/ready stream on both sides: PHY/backend read-return data in, cache/frontend consumer out.

## Interface
- `BufferDepth`, default 16: entries in the buffer; power of two, ≥2.
- `AlmostFullThr`, default `BufferDepth-2`: `almost_full` asserts when `level >= AlmostFullThr`; range 1..BufferDepth.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all contents; priority over all other inputs.
- `wr_valid`  in  1  producer has a beat.
- `wr_ready`  out  1  FIFO accepts the beat; equals `mem_cnt < BufferDepth`.
- `wr_data`  in  MEM_DATAWIDTH  write beat.
- `rd_valid`  out  1  output register holds a beat.
- `rd_ready`  in  1  consumer takes the beat.
- `rd_data`  out  MEM_DATAWIDTH  output beat; driven directly by `DualPortBuffer.rdata`.
- `level`  out  $clog2(BufferDepth)+1  total beats held: `mem_cnt + rd_valid`.
- `almost_full`  out  1  `level >= AlmostFullThr`.
- `empty`  out  1  `level == 0`.

## Operation
- Internal state:
  - `wptr`, `rptr`: $clog2(BufferDepth) bits each; wrap naturally modulo BufferDepth.
  - `mem_cnt`: $clog2(BufferDepth)+1 bits, range 0..BufferDepth. Counts beats written but not yet read out of the memory.
  - `rd_valid` flag.
- Write accept: `push = wr_valid && wr_ready && !flush`. Drives `we` and `writePtr = wptr`. `wptr` increments on push.
- Read issue: `pop = (mem_cnt != 0) && (!rd_valid || rd_ready) && !flush`. Drives `re` and `readPtr = rptr`. `rptr` increments on pop.
- Occupancy update:
  - `mem_cnt` increments on push only, decrements on pop only, and is unchanged on both.
  - Arithmetic never wraps: push is blocked at BufferDepth, pop is blocked at 0.
- `rd_valid` next state:
  - set on pop;
  - else cleared if `rd_ready`;
  - else held.
- Hazard freedom:
  - pop requires `mem_cnt ≥ 1`; push requires `mem_cnt ≤ BufferDepth-1`.
  - With both true, `rptr != wptr`, so the buffer never sees equal pointers with `re && we`.
  - Any violation is an RTL bug. Add an `ASSERTION`-guarded check.
- Effective capacity is BufferDepth+1 beats: the full memory plus the output register.
- Stalled output: while `rd_valid && !rd_ready`, `rd_data` holds because `re` is low.
- Flush:
  - Next cycle: `wptr = rptr = 0`, `mem_cnt = 0`, `rd_valid = 0`.
  - A write presented during the flush cycle is dropped.
  - Memory contents are not cleared.
- Reset (async assert):
  - Pointers, `mem_cnt` and `rd_valid` go to 0.
  - The buffer clears `rd_data` to 0.
  - Outputs then read: `wr_ready = 1`, `level = 0`, `empty = 1`, `almost_full = 0` (given `AlmostFullThr ≥ 1`).
  - Reset mid-transfer discards all data.

## Timing
- Write→read latency, empty FIFO: push in cycle N → `mem_cnt = 1` in N+1 → pop in N+1 → `rd_valid` and `rd_data` valid in N+2.
- Throughput: one beat per cycle sustained on both sides, with `rd_ready` held high and `mem_cnt > 0`.
- `wr_ready`, `level`, `empty` and `almost_full` are functions of registered state only. No combinational path from `wr_valid` or `rd_ready`.
- `rd_valid` is registered.
- `rd_data` changes only on the cycle after a pop.

## Structure
- `MEM_DATAWIDTH` comes from the shared `MemoryController_Definitions` package.
- Add no new package types. The count/pointer widths are derived locally from BufferDepth.
- Exactly one sub-module: `DualPortBuffer` (#BufferDepth), instantiated once, with clock and reset passed straight through.
- The controller holds pointers, counters, flags and the handshake logic; no other storage.

## Test plan
- **Reset:** assert `rst` low mid-stream with `level = 5` → immediately `level = 0`, `empty = 1`, `rd_valid = 0`, `rd_data = 0`, `wr_ready = 1`.
- **Single beat:** write 0xA5 at cycle N with `rd_ready = 1` → `rd_valid = 1`, `rd_data = 0xA5` at N+2; `empty = 1` at N+3.
- **Fill with consumer stalled:** BufferDepth=16, `rd_ready = 0`, write 0..20 continuously:
  - exactly 17 beats are accepted; `wr_ready` falls after 17; `level = 17`;
  - `almost_full` rises at `level = 14`;
  - then drain with `rd_ready = 1` → data out 0..16 in order, no gaps.
- **Full-rate streaming:** simultaneous streaming, 1000 random beats, `wr_valid = rd_ready = 1` → in-order output; `level` constant at steady state; the hazard assertion never fires.
- **Pointer wrap with random stalls:** random `wr_valid` / `rd_ready` (50%) over 5×BufferDepth beats → scoreboard match, `level` always equals pushes − pops.
- **Flush with data:** `flush` pulsed with `level = 9` and `wr_valid = 1` → next cycle `level = 0` and `rd_valid = 0`; the flush-cycle write is dropped; subsequent write 0x3C emerges 2 cycles later.

Source files
------------

// File: rtl/dual_port_fifo_ctrl_pkg.sv
// Shared memory-controller definitions.
// Data width used by the FIFO controller and its buffer.
package MemoryController_Definitions;

  localparam int MEM_DATAWIDTH = 32;

endpackage

// File: rtl/dual_port_fifo_ctrl_buf.sv
// Dual-port storage: one write port, one registered read port.
// Pointers are supplied by the owning controller.
module DualPortBuffer
  import MemoryController_Definitions::*;
#(
  parameter int BufferDepth = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [$clog2(BufferDepth)-1:0]   writePtr,
  input  logic [MEM_DATAWIDTH-1:0]         wdata,
  input  logic                             re,
  input  logic [$clog2(BufferDepth)-1:0]   readPtr,
  output logic [MEM_DATAWIDTH-1:0]         rdata
);

  logic [MEM_DATAWIDTH-1:0] mem [BufferDepth];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[writePtr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[readPtr];
  end

endmodule

// File: rtl/dual_port_fifo_ctrl.sv
// Valid/ready FIFO controller around DualPortBuffer.
// Capacity is BufferDepth beats in memory plus the output register.
module dual_port_fifo_ctrl
  import MemoryController_Definitions::*;
#(
  parameter int BufferDepth   = 16,
  parameter int AlmostFullThr = BufferDepth - 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [MEM_DATAWIDTH-1:0]       wr_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [MEM_DATAWIDTH-1:0]       rd_data,
  output logic [$clog2(BufferDepth):0]   level,
  output logic                           almost_full,
  output logic                           empty
);

  localparam int PW = $clog2(BufferDepth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(BufferDepth);
  localparam logic [CW-1:0] THR   = CW'(AlmostFullThr);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] mem_cnt;
  logic          push;
  logic          pop;

  assign wr_ready    = mem_cnt < DEPTH;
  assign push        = wr_valid && wr_ready && !flush;
  assign pop         = (mem_cnt != '0)
                    && (!rd_valid || rd_ready)
                    && !flush;
  assign level       = mem_cnt + CW'(rd_valid);
  assign almost_full = level >= THR;
  assign empty       = level == '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case (1'b1)
        (push && !pop): mem_cnt <= mem_cnt + CW'(1);
        (pop && !push): mem_cnt <= mem_cnt - CW'(1);
        default: ;
      endcase
      if (pop)           rd_valid <= 1'b1;
      else if (rd_ready) rd_valid <= 1'b0;
    end
  end

  DualPortBuffer #(
    .BufferDepth(BufferDepth)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .we       (push),
    .writePtr (wptr),
    .wdata    (wr_data),
    .re       (pop),
    .readPtr  (rptr),
    .rdata    (rd_data)
  );

`ifdef ASSERTION
  // Occupancy bounds imply distinct pointers whenever both ports fire.
  always_ff @(posedge clk) begin
    if (rst && push && pop)
      assert (wptr != rptr)
        else $error("buffer read/write pointer hazard");
  end
`endif

endmodule

// File: tb/tb_dual_port_fifo_ctrl.sv
// Directed and scoreboard bench for dual_port_fifo_ctrl.
// Depth 16, almost-full threshold 14.
module tb_dual_port_fifo_ctrl;
  import MemoryController_Definitions::*;

  localparam int D  = 16;
  localparam int W  = MEM_DATAWIDTH;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_fifo_ctrl #(
    .BufferDepth(D),
    .AlmostFullThr(D - 2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .almost_full (almost_full),
    .empty       (empty)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic         fl;
    logic         wv;
    logic [W-1:0] wd;
    logic         rr;
    logic         e_wrdy;
    logic         e_rv;
    logic [W-1:0] e_rd;
    int           e_lvl;
    logic         e_af;
    logic         e_emp;
  } vec_t;

  vec_t vt[13];

  logic [W-1:0] q[$];
  int           seq;
  int           sent;

  task automatic sb_cycle(input logic rwv, input logic rrr);
    @(negedge clk);
    chk("sb.level", 64'(level), 64'(q.size()));
    if (rd_valid && rrr) begin
      if (q.size() == 0) begin
        chk("sb.spurious", 64'(rd_valid), 64'(0));
      end else begin
        chk("sb.data", 64'(rd_data), 64'(q[0]));
        void'(q.pop_front());
      end
    end
    if (rwv && wr_ready) begin
      q.push_back(W'(seq));
      sent++;
    end
    wr_valid = rwv;
    wr_data  = W'(seq);
    rd_ready = rrr;
    if (rwv && wr_ready) seq++;
  endtask

  initial begin
    int acc;
    vt[0]  = '{0, 1, 'hA5, 1, 1, 0, 'h00, 0, 0, 1};
    vt[1]  = '{0, 0, 'h00, 1, 1, 0, 'h00, 1, 0, 0};
    vt[2]  = '{0, 0, 'h00, 1, 1, 1, 'hA5, 1, 0, 0};
    vt[3]  = '{0, 1, 'h11, 0, 1, 0, 'hA5, 0, 0, 1};
    vt[4]  = '{0, 1, 'h22, 0, 1, 0, 'hA5, 1, 0, 0};
    vt[5]  = '{0, 0, 'h00, 0, 1, 1, 'h11, 2, 0, 0};
    vt[6]  = '{0, 0, 'h00, 1, 1, 1, 'h11, 2, 0, 0};
    vt[7]  = '{0, 0, 'h00, 0, 1, 1, 'h22, 1, 0, 0};
    vt[8]  = '{1, 1, 'h99, 1, 1, 1, 'h22, 1, 0, 0};
    vt[9]  = '{0, 1, 'h3C, 1, 1, 0, 'h22, 0, 0, 1};
    vt[10] = '{0, 0, 'h00, 1, 1, 0, 'h22, 1, 0, 0};
    vt[11] = '{0, 0, 'h00, 1, 1, 1, 'h3C, 1, 0, 0};
    vt[12] = '{0, 0, 'h00, 1, 1, 0, 'h3C, 0, 0, 1};

    #12;
    chk("rst.wr_ready", 64'(wr_ready), 64'(1));
    chk("rst.level", 64'(level), 64'(0));
    chk("rst.empty", 64'(empty), 64'(1));
    chk("rst.af", 64'(almost_full), 64'(0));
    chk("rst.rd_valid", 64'(rd_valid), 64'(0));
    chk("rst.rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.wr_ready", i),
          64'(wr_ready), 64'(vt[i].e_wrdy));
      chk($sformatf("v%0d.rd_valid", i),
          64'(rd_valid), 64'(vt[i].e_rv));
      chk($sformatf("v%0d.rd_data", i),
          64'(rd_data), 64'(vt[i].e_rd));
      chk($sformatf("v%0d.level", i),
          64'(level), 64'(vt[i].e_lvl));
      chk($sformatf("v%0d.af", i),
          64'(almost_full), 64'(vt[i].e_af));
      chk($sformatf("v%0d.empty", i),
          64'(empty), 64'(vt[i].e_emp));
      flush    = vt[i].fl;
      wr_valid = vt[i].wv;
      wr_data  = vt[i].wd;
      rd_ready = vt[i].rr;
    end

    // Fill with the consumer stalled.
    rd_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk("fill.level", 64'(level), 64'(acc));
      chk("fill.wr_ready", 64'(wr_ready),
          64'(acc < D + 1));
      chk("fill.af", 64'(almost_full),
          64'(acc >= D - 2));
      wr_valid = 1'b1;
      wr_data  = W'(acc);
      if (wr_ready) acc++;
    end
    chk("fill.accepted", 64'(acc), 64'(D + 1));
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k <= D; k++) begin
      chk("drain.rd_valid", 64'(rd_valid), 64'(1));
      chk("drain.rd_data", 64'(rd_data), 64'(k));
      @(negedge clk);
    end
    chk("drain.rd_valid_end", 64'(rd_valid), 64'(0));
    chk("drain.empty", 64'(empty), 64'(1));

    // Flush with 9 beats held and a write present.
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = W'(32'h100 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("flush.pre_level", 64'(level), 64'(9));
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = W'(32'h77);
    @(negedge clk);
    flush = 1'b0;
    chk("flush.level", 64'(level), 64'(0));
    chk("flush.rd_valid", 64'(rd_valid), 64'(0));
    wr_data  = W'(32'h3C);
    rd_ready = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("flush.post_level", 64'(level), 64'(1));
    @(negedge clk);
    chk("flush.post_rv", 64'(rd_valid), 64'(1));
    chk("flush.post_data", 64'(rd_data), 64'(32'h3C));
    @(negedge clk);
    chk("flush.post_empty", 64'(empty), 64'(1));

    // Full-rate streaming.
    seq  = 32'h1000;
    sent = 0;
    for (int c = 0; c < 5000 && sent < 1000; c++)
      sb_cycle(1'b1, 1'b1);
    chk("stream.sent", 64'(sent), 64'(1000));
    for (int c = 0; c < 100 && q.size() > 0; c++)
      sb_cycle(1'b0, 1'b1);
    chk("stream.drained", 64'(q.size()), 64'(0));

    // Random stalls across several pointer wraps.
    sent = 0;
    for (int c = 0; c < 5000 && sent < 5 * D; c++)
      sb_cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int c = 0; c < 200 && q.size() > 0; c++)
      sb_cycle(1'b0, 1'($urandom_range(1)));
    chk("rand.drained", 64'(q.size()), 64'(0));
    sb_cycle(1'b0, 1'b1);
    sb_cycle(1'b0, 1'b1);

    // Asynchronous reset with 5 beats held.
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = W'(32'h200 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("arst.pre_level", 64'(level), 64'(5));
    #2 rst = 1'b0;
    #1;
    chk("arst.level", 64'(level), 64'(0));
    chk("arst.empty", 64'(empty), 64'(1));
    chk("arst.rd_valid", 64'(rd_valid), 64'(0));
    chk("arst.rd_data", 64'(rd_data), 64'(0));
    chk("arst.wr_ready", 64'(wr_ready), 64'(1));
    chk("arst.af", 64'(almost_full), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
